// File: rtl/pc_redirect_unit.sv
// Fetch-address sequencer: picks the next PC from EX-stage redirects, halts and
// hazard stalls, and raises a fixed-length squash strobe after every redirect.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        should_jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        halted,
  output logic [15:0] redirect_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } unitState_t;

  // The counter is loaded with one less than the strobe length because the
  // redirect cycle itself already drives flush high.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  unitState_t  state;
  logic [1:0]  flushCnt;
  logic        haltEvent;
  logic        jumpEvent;
  logic        unusedTgtBits;

  function automatic logic [15:0] satInc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  assign haltEvent     = ex_valid & halt_req;
  assign jumpEvent     = ex_valid & should_jump;
  assign pc_plus4      = pc + 32'd4;
  assign unusedTgtBits = ^jump_target[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= RUN;
      pc             <= RESET_PC;
      flush          <= 1'b0;
      halted         <= 1'b0;
      redirect_count <= 16'd0;
      flushCnt       <= 2'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (haltEvent) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (jumpEvent) begin
            // Redirect outranks stall: the EX instruction is older than the stalled one.
            pc             <= {jump_target[31:2], 2'b00};
            flush          <= 1'b1;
            flushCnt       <= FLUSH_LOAD;
            state          <= FLUSH;
            redirect_count <= satInc(redirect_count);
          end else if (!stall) begin
            pc <= pc_plus4;
          end
        end
        FLUSH: begin
          pc <= pc_plus4;
          if (flushCnt != 2'd0) begin
            flushCnt <= flushCnt - 2'd1;
          end else begin
            flush <= 1'b0;
            state <= RUN;
          end
        end
        HALTED: begin
          flush  <= 1'b0;
          halted <= 1'b1;
        end
        default: begin
          state <= RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: a behavioural next-state model pushes the
// expected outputs of every clock edge into a queue that is popped after the edge.
module tb_pc_redirect_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FC       = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        exValid;
  logic        shouldJump;
  logic [31:0] jumpTarget;
  logic        stall;
  logic        haltReq;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        flush;
  logic        halted;
  logic [15:0] redirectCount;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        halted;
    logic [15:0] cnt;
  } expect_t;

  expect_t     sb[$];
  logic [31:0] mPc;
  int          mFlushLeft;
  logic        mHalted;
  logic [15:0] mCnt;
  int          vectors     = 0;
  int          miscompares = 0;
  int          stepNo      = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(
    .RESET_PC    (RESET_PC),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (exValid),
    .should_jump   (shouldJump),
    .jump_target   (jumpTarget),
    .stall         (stall),
    .halt_req      (haltReq),
    .pc            (pc),
    .pc_plus4      (pcPlus4),
    .flush         (flush),
    .halted        (halted),
    .redirect_count(redirectCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s@step%0d observed=0x%08h expected=0x%08h", tag, stepNo, obs, exp);
    end
  endtask

  // Behavioural model of one rising edge given the inputs held during that cycle.
  task automatic modelEdge(input logic ev, input logic sj, input logic [31:0] tgt,
                           input logic st, input logic hr);
    expect_t e;
    if (mHalted) begin
    end else if (mFlushLeft > 0) begin
      mPc = mPc + 32'd4;
      mFlushLeft--;
    end else if (ev && hr) begin
      mHalted = 1'b1;
    end else if (ev && sj) begin
      mPc        = tgt & 32'hFFFF_FFFC;
      mFlushLeft = FC;
      if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
    end else if (!st) begin
      mPc = mPc + 32'd4;
    end
    e.pc     = mPc;
    e.flush  = (mFlushLeft > 0);
    e.halted = mHalted;
    e.cnt    = mCnt;
    sb.push_back(e);
  endtask

  task automatic compareOut();
    expect_t e;
    vectors++;
    assert (sb.size() > 0) else begin
      miscompares++;
      $error("FAIL scoreboard_empty@step%0d observed=%0d expected=1", stepNo, sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pc",             pc,                     e.pc);
      check("pc_plus4",       pcPlus4,                e.pc + 32'd4);
      check("flush",          {31'd0, flush},         {31'd0, e.flush});
      check("halted",         {31'd0, halted},        {31'd0, e.halted});
      check("redirect_count", {16'd0, redirectCount}, {16'd0, e.cnt});
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic ev, input logic sj, input logic [31:0] tgt,
                       input logic st, input logic hr);
    stepNo++;
    exValid    = ev;
    shouldJump = sj;
    jumpTarget = tgt;
    stall      = st;
    haltReq    = hr;
    modelEdge(ev, sj, tgt, st, hr);
    @(posedge clk);
    #1;
    compareOut();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // Asserts reset away from any clock edge and checks that it acts at once.
  task automatic applyReset();
    stepNo++;
    #2 rst = 1'b0;
    #1;
    check("rst_pc",       pc,                     RESET_PC);
    check("rst_pc_plus4", pcPlus4,                RESET_PC + 32'd4);
    check("rst_flush",    {31'd0, flush},         32'd0);
    check("rst_halted",   {31'd0, halted},        32'd0);
    check("rst_count",    {16'd0, redirectCount}, 32'd0);
    mPc        = RESET_PC;
    mFlushLeft = 0;
    mHalted    = 1'b0;
    mCnt       = 16'd0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    exValid    = 1'b0;
    shouldJump = 1'b0;
    jumpTarget = 32'd0;
    stall      = 1'b0;
    haltReq    = 1'b0;
    mPc        = RESET_PC;
    mFlushLeft = 0;
    mHalted    = 1'b0;
    mCnt       = 16'd0;
    @(negedge clk);
    applyReset();

    // Sequential fetch from reset up to 0x10.
    idle(4);

    // Redirect to a misaligned target; flush for two cycles.
    cycle(1'b1, 1'b1, 32'h0000_0103, 1'b0, 1'b0);
    idle(3);

    // Plain stall holds pc.
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Redirect with simultaneous stall, stall held; a jump inside FLUSH is ignored.
    cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    idle(1);

    // Unqualified requests do nothing.
    cycle(1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0000_0600, 1'b0, 1'b1);

    // Redirect onto the current pc still flushes and counts.
    cycle(1'b1, 1'b1, mPc, 1'b0, 1'b0);
    idle(3);

    // Reset in the middle of a flush, then fetch resumes at RESET_PC+4.
    cycle(1'b1, 1'b1, 32'h0000_0800, 1'b0, 1'b0);
    applyReset();
    idle(2);

    // Reach 0x40, then halt with a simultaneous jump; events are ignored afterwards.
    cycle(1'b1, 1'b1, 32'h0000_0038, 1'b0, 1'b0);
    idle(2);
    cycle(1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0090, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    idle(2);
    applyReset();

    // Address wrap past 0xFFFF_FFFC.
    cycle(1'b1, 1'b1, 32'hFFFF_FFF2, 1'b0, 1'b0);
    idle(5);

    // Counter held at its ceiling across a redirect, then one more redirect.
    force dut.redirect_count = 16'hFFFF;
    mCnt = 16'hFFFF;
    cycle(1'b1, 1'b1, 32'h0000_1000, 1'b0, 1'b0);
    release dut.redirect_count;
    idle(2);
    cycle(1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..3: number of cycles flush is held after a redirect.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the single clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ex_valid  input  1  EX stage holds a valid (unsquashed) instruction.
REQ-006 SHALL have port should_jump  input  1  branch-taken/jump decision for the EX instruction.
REQ-007 SHALL have port jump_target  input  32  target address for the EX instruction.
REQ-008 SHALL have port stall  input  1  hazard hold request from the hazard unit.
REQ-009 SHALL have port halt_req  input  1  EX instruction is ECALL/EBREAK/halt.
REQ-010 SHALL have port pc  output  32  registered fetch address.
REQ-011 SHALL have port pc_plus4  output  32  combinational pc + 4, modulo 2^32.
REQ-012 SHALL have port flush  output  1  registered squash strobe for the IF/ID and ID/EX registers.
REQ-013 SHALL have port halted  output  1  registered; core is halted.
REQ-014 SHALL have port redirect_count  output  16  registered count of taken redirects.

Function
REQ-015 SHALL implement three states: RUN, FLUSH, HALTED; state, pc, flush, halted, redirect_count and the flush counter are the only registers.
REQ-016 SHALL define "event" per cycle as the request inputs qualified by ex_valid; in FLUSH and HALTED, event inputs SHALL be ignored.
REQ-017 In RUN, SHALL apply this priority per cycle: halt_req&ex_valid, then should_jump&ex_valid, then stall, then sequential fetch.
REQ-018 In RUN on halt: pc holds, halted <= 1 next cycle, state -> HALTED, redirect_count unchanged, flush stays 0.
REQ-019 In RUN on redirect: pc <= {jump_target[31:2], 2'b00}; flush <= 1; flush counter <= FLUSH_CYCLES-1; state -> FLUSH; redirect_count increments.
REQ-020 A redirect SHALL win over a simultaneous stall, because the EX instruction is older than the stalled one.
REQ-021 In RUN on stall with no event: pc, flush and state hold.
REQ-022 In RUN otherwise: pc <= pc_plus4.
REQ-023 In FLUSH: pc <= pc_plus4 every cycle; stall is ignored; flush stays 1 while the counter is nonzero, and the counter decrements each cycle.
REQ-024 In FLUSH, when the counter is 0: flush <= 0 next cycle and state -> RUN, so flush is high for exactly FLUSH_CYCLES consecutive cycles.
REQ-025 In HALTED: pc frozen, flush 0, halted 1; only reset exits.
REQ-026 redirect_count SHALL saturate at 16'hFFFF.
REQ-027 pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-028 A redirect whose target equals the current pc SHALL be treated as a normal redirect: it flushes and counts.
REQ-029 jump_target[1:0] SHALL be discarded; no misalignment exception is raised by this block.

Reset
REQ-030 On rst low, SHALL immediately set pc=RESET_PC, state=RUN, flush=0, halted=0, redirect_count=0 and flush counter=0, regardless of clk.
REQ-031 Reset asserted mid-FLUSH or in HALTED SHALL abort the operation; the first rising edge after release fetches RESET_PC+4 when no event or stall is present.

Verification
REQ-032 Reset release with idle inputs -> pc sequence 0x0, 0x4, 0x8; flush=0; redirect_count=0.
REQ-033 At pc=0x10, pulse ex_valid=1, should_jump=1, jump_target=0x103 -> next pc=0x100, flush high for 2 cycles while pc=0x100 and 0x104, then pc=0x108 with flush=0; redirect_count=1.
REQ-034 Redirect plus stall in the same cycle, then stall held for 3 more cycles -> redirect taken; stall ignored in FLUSH; pc advances each flush cycle.
REQ-035 should_jump=1 with ex_valid=0, and should_jump=1 during FLUSH -> no redirect and no count increment.
REQ-036 halt_req=1, should_jump=1, ex_valid=1 at pc=0x40 -> pc frozen at 0x40, halted=1, count unchanged; then rst low -> pc=0x0, halted=0.
REQ-037 Preload redirect_count to 0xFFFF via 65535 redirects, then one more redirect -> stays 0xFFFF; separately, pc=0xFFFF_FFFC sequential -> 0x0.
